// File: rtl/game_pkg.sv
// game_pkg: match states and winner codes shared by
// game_logic, game_flow_ctrl and the overlay renderer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_PEER  = 3'd1,
    COUNTDOWN  = 3'd2,
    PLAY       = 3'd3,
    RESULT     = 3'd4,
    MATCH_OVER = 3'd5
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  function automatic logic [3:0] sat_inc(
    input logic [3:0] v
  );
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/sec_tick.sv
// sec_tick: prescaler, one-cycle o_tick every CLK_HZ cycles.
// Ports: i_clk, i_rst (sync, high), i_clr (restart count), o_tick.
module sec_tick #(
  parameter int CLK_HZ = 65_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int W =
    (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: ready handshake, countdown, play, result hold
// and best-of match score around game_logic.
// Ports: clk, rst (sync, high), mouse_left_local, remote_ready,
// winner_valid/winner_code in; game_rst, local_ready, state,
// countdown, score1, score2, last_result out (all registered).
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int CLK_HZ          = 65_000_000,
  parameter int COUNT_SEC       = 3,
  parameter int RESULT_HOLD_SEC = 2,
  parameter int WIN_SCORE       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mouse_left_local,
  input  logic       remote_ready,
  input  logic       winner_valid,
  input  logic [1:0] winner_code,
  output logic       game_rst,
  output logic       local_ready,
  output state_t     state,
  output logic [1:0] countdown,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] last_result
);

  localparam logic [1:0] CD_LOAD = COUNT_SEC[1:0];
  localparam int HW =
    (RESULT_HOLD_SEC > 1) ? $clog2(RESULT_HOLD_SEC + 1) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(RESULT_HOLD_SEC);
  localparam logic [3:0] WIN = WIN_SCORE[3:0];

  state_t        r_state;
  logic          r_game_rst;
  logic          r_local_ready;
  logic [1:0]    r_countdown;
  logic [3:0]    r_score1;
  logic [3:0]    r_score2;
  logic [1:0]    r_last;
  logic [HW-1:0] r_hold;
  logic          r_mouse_d;

  logic w_click;
  logic w_win_ok;
  logic w_clr;
  logic w_tick;

  assign w_click  = mouse_left_local & ~r_mouse_d;
  assign w_win_ok = winner_valid && (winner_code != WIN_NONE);

  // Restart the prescaler on the cycle we enter a timed phase.
  assign w_clr =
    ((r_state == WAIT_PEER) && r_local_ready && remote_ready) ||
    ((r_state == PLAY) && w_win_ok);

  sec_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_clr),
    .o_tick(w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_game_rst    <= 1'b1;
      r_local_ready <= 1'b0;
      r_countdown   <= 2'd0;
      r_score1      <= 4'd0;
      r_score2      <= 4'd0;
      r_last        <= WIN_NONE;
      r_hold        <= '0;
      // Preset high so the first cycle after reset never
      // looks like a rising edge.
      r_mouse_d     <= 1'b1;
    end else begin
      r_mouse_d <= mouse_left_local;
      unique case (r_state)
        IDLE: begin
          if (w_click) begin
            r_local_ready <= 1'b1;
            r_state       <= WAIT_PEER;
          end
        end
        WAIT_PEER: begin
          if (r_local_ready && remote_ready) begin
            r_countdown <= CD_LOAD;
            r_state     <= COUNTDOWN;
          end
        end
        COUNTDOWN: begin
          if (w_tick) begin
            if (r_countdown <= 2'd1) begin
              r_countdown <= 2'd0;
              r_game_rst  <= 1'b0;
              r_state     <= PLAY;
            end else begin
              r_countdown <= r_countdown - 2'd1;
            end
          end
        end
        PLAY: begin
          if (w_win_ok) begin
            unique case (winner_code)
              WIN_P1:  r_score1 <= sat_inc(r_score1);
              WIN_P2:  r_score2 <= sat_inc(r_score2);
              default: ;
            endcase
            r_last     <= winner_code;
            r_hold     <= HOLD_LOAD;
            r_game_rst <= 1'b1;
            r_state    <= RESULT;
          end
        end
        RESULT: begin
          if (w_tick) begin
            if (r_hold <= HW'(1)) begin
              if (r_score1 == WIN || r_score2 == WIN) begin
                r_state <= MATCH_OVER;
              end else begin
                r_local_ready <= 1'b0;
                r_state       <= IDLE;
              end
            end else begin
              r_hold <= r_hold - HW'(1);
            end
          end
        end
        MATCH_OVER: begin
          if (w_click) begin
            r_score1      <= 4'd0;
            r_score2      <= 4'd0;
            r_last        <= WIN_NONE;
            r_local_ready <= 1'b0;
            r_state       <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign state       = r_state;
  assign game_rst    = r_game_rst;
  assign local_ready = r_local_ready;
  assign countdown   = r_countdown;
  assign score1      = r_score1;
  assign score2      = r_score2;
  assign last_result = r_last;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed + random stimulus, cycle-level
// reference model feeding a scoreboard queue.
module tb_game_flow_ctrl;
  import game_pkg::*;

  localparam int HZ = 10;
  localparam int CS = 3;
  localparam int HS = 1;
  localparam int WS = 2;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       mouse = 1'b0;
  logic       rr    = 1'b0;
  logic       wv    = 1'b0;
  logic [1:0] wc    = 2'b00;

  logic       game_rst;
  logic       local_ready;
  state_t     state;
  logic [1:0] countdown;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] last_result;

  always #5 clk = ~clk;

  game_flow_ctrl #(
    .CLK_HZ         (HZ),
    .COUNT_SEC      (CS),
    .RESULT_HOLD_SEC(HS),
    .WIN_SCORE      (WS)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mouse_left_local(mouse),
    .remote_ready    (rr),
    .winner_valid    (wv),
    .winner_code     (wc),
    .game_rst        (game_rst),
    .local_ready     (local_ready),
    .state           (state),
    .countdown       (countdown),
    .score1          (score1),
    .score2          (score2),
    .last_result     (last_result)
  );

  typedef struct packed {
    state_t     st;
    logic       grst;
    logic       rdy;
    logic [1:0] cd;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] lr;
  } obs_t;

  obs_t exp_q[$];
  int   n_pass = 0;
  int   n_chk  = 0;
  int   cyc    = 0;

  // Reference model: phases timed in raw clock cycles
  state_t     m_ph    = IDLE;
  int         m_rem   = 0;
  bit         m_rdy   = 0;
  int         m_s1    = 0;
  int         m_s2    = 0;
  logic [1:0] m_last  = 2'b00;
  bit         m_prev  = 0;
  bit         m_armed = 0;
  bit         m_click;
  obs_t       m_e;

  always @(posedge clk) begin
    if (rst) begin
      m_ph = IDLE; m_rem = 0; m_rdy = 0;
      m_s1 = 0; m_s2 = 0; m_last = 2'b00;
      m_armed = 0;
    end else begin
      m_click = m_armed && mouse && !m_prev;
      case (m_ph)
        IDLE: if (m_click) begin
          m_rdy = 1; m_ph = WAIT_PEER;
        end
        WAIT_PEER: if (rr) begin
          m_ph = COUNTDOWN; m_rem = CS * HZ;
        end
        COUNTDOWN: begin
          m_rem--;
          if (m_rem == 0) m_ph = PLAY;
        end
        PLAY: if (wv && wc != 2'b00) begin
          if (wc == 2'b01 && m_s1 < 15) m_s1++;
          if (wc == 2'b10 && m_s2 < 15) m_s2++;
          m_last = wc; m_ph = RESULT; m_rem = HS * HZ;
        end
        RESULT: begin
          m_rem--;
          if (m_rem == 0) begin
            if (m_s1 == WS || m_s2 == WS) m_ph = MATCH_OVER;
            else begin m_ph = IDLE; m_rdy = 0; end
          end
        end
        MATCH_OVER: if (m_click) begin
          m_s1 = 0; m_s2 = 0; m_last = 2'b00;
          m_rdy = 0; m_ph = IDLE;
        end
        default: m_ph = IDLE;
      endcase
      m_prev = mouse; m_armed = 1;
    end
    m_e.st   = m_ph;
    m_e.grst = (m_ph != PLAY);
    m_e.rdy  = m_rdy;
    m_e.cd   = (m_ph == COUNTDOWN) ? 2'((m_rem + HZ - 1) / HZ) : 2'd0;
    m_e.s1   = 4'(m_s1);
    m_e.s2   = 4'(m_s2);
    m_e.lr   = m_last;
    exp_q.push_back(m_e);
  end

  // Monitor: compare every settled output against the scoreboard
  obs_t a;
  obs_t e;
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.st = state; a.grst = game_rst; a.rdy = local_ready;
      a.cd = countdown; a.s1 = score1; a.s2 = score2;
      a.lr = last_result;
      n_chk++;
      if (a === e) n_pass++;
      else $display(
        "FAIL outputs@cyc%0d got st=%0d grst=%0b rdy=%0b cd=%0d s1=%0d s2=%0d lr=%b exp st=%0d grst=%0b rdy=%0b cd=%0d s1=%0d s2=%0d lr=%b",
        cyc, a.st, a.grst, a.rdy, a.cd, a.s1, a.s2, a.lr,
        e.st, e.grst, e.rdy, e.cd, e.s1, e.s2, e.lr);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic click();
    mouse = 1'b1; step(1); mouse = 1'b0; step(1);
  endtask

  task automatic pulse(input logic [1:0] c);
    wv = 1'b1; wc = c; step(1); wv = 1'b0; wc = 2'b00;
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    step(2);
    // Long peer wait, then countdown into PLAY
    click();
    step(50);
    rr = 1'b1;
    step(35);
    pulse(2'b10);
    step(15);
    // Peer already ready: draw round
    click();
    step(35);
    pulse(2'b11);
    step(15);
    // Code 00 ignored, then P1 scores
    click();
    step(35);
    pulse(2'b00);
    step(3);
    pulse(2'b01);
    step(15);
    click();
    step(35);
    pulse(2'b01);
    step(15);
    // MATCH_OVER: stray result ignored, click restarts
    pulse(2'b10);
    step(2);
    click();
    step(3);
    pulse(2'b01);
    step(2);
    // Click held level through a whole round
    mouse = 1'b1;
    step(3);
    pulse(2'b10);
    step(35);
    step(5);
    pulse(2'b01);
    step(15);
    step(5);
    mouse = 1'b0;
    step(2);
    click();
    step(12);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);
    // Randomized traffic
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 19) == 0) mouse = ~mouse;
      if ($urandom_range(0, 39) == 0) rr = ~rr;
      if ($urandom_range(0, 11) == 0) begin
        wv = 1'b1; wc = 2'($urandom_range(0, 3));
      end else begin
        wv = 1'b0; wc = 2'b00;
      end
      rst = ($urandom_range(0, 2999) == 0);
      step(1);
    end
    rst = 1'b0; wv = 1'b0;
    step(3);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard drain got %0d left, need 0",
                  exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Match-level controller that consumes the per-round `winner_valid`/`winner_code` pulse from `game_logic` and drives its `game_rst`. It runs the two-player ready handshake, a start countdown, the play phase, the result hold and the best-of match score. It sits between mouse/link inputs and `game_logic`, and feeds state, scores and countdown to the overlay renderer.

## Interface
Parameters:
- `CLK_HZ`, 65_000_000, clock cycles per second (one countdown tick).
- `COUNT_SEC`, 3, countdown length in ticks.
- `RESULT_HOLD_SEC`, 2, result display length in ticks.
- `WIN_SCORE`, 5, points that end the match (1..15).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `mouse_left_local`  in  1  local button, level, already synchronised.
- `remote_ready`  in  1  peer ready flag from the link, level.
- `winner_valid`  in  1  one-cycle round-end pulse from `game_logic`.
- `winner_code`  in  2  bit1 = bird1 crashed, bit0 = bird2 crashed; 00 is not used.
- `game_rst`  out  1  held high in every state except PLAY.
- `local_ready`  out  1  to link: local player is ready.
- `state`  out  3  current state, encoded as `game_pkg::state_t`.
- `countdown`  out  2  remaining ticks in COUNTDOWN, otherwise 0.
- `score1`, `score2`  out  4  match points for player 1 and player 2.
- `last_result`  out  2  last `winner_code` accepted; 00 after reset or a new match.

## Operation
- States are IDLE, WAIT_PEER, COUNTDOWN, PLAY, RESULT, MATCH_OVER.
- The local click is the rising edge of `mouse_left_local`, taken from a 1-cycle delayed copy. The first cycle after reset never counts as an edge.
- IDLE:
  - On a click, set `local_ready`=1 and go to WAIT_PEER.
- WAIT_PEER:
  - When `local_ready` && `remote_ready`, go to COUNTDOWN, load `countdown`=COUNT_SEC and clear the tick prescaler.
  - If `remote_ready` is already high when the click arrives, WAIT_PEER still lasts exactly 1 cycle.
- COUNTDOWN:
  - Each time the prescaler reaches CLK_HZ-1, it wraps to 0 and `countdown` decrements.
  - The tick that would make `countdown` 0 moves the FSM to PLAY instead, with `countdown`=0.
- PLAY:
  - `game_rst`=0.
  - On `winner_valid`:
    - 2'b10 gives `score2`+1.
    - 2'b01 gives `score1`+1.
    - 2'b11 is a draw; no score change.
    - 2'b00 is ignored and the FSM stays in PLAY.
  - For codes other than 00, latch `last_result`, clear the prescaler and go to RESULT.
- RESULT:
  - Hold for RESULT_HOLD_SEC ticks.
  - Then go to MATCH_OVER if `score1`==WIN_SCORE or `score2`==WIN_SCORE. Otherwise clear `local_ready` and go to IDLE.
- MATCH_OVER:
  - On a click, clear both scores and `last_result`, clear `local_ready` and go to IDLE.
- `winner_valid` outside PLAY is ignored.
- Clicks are ignored in WAIT_PEER, COUNTDOWN, PLAY and RESULT.
- Scores are 4-bit and saturate at 15. With WIN_SCORE ≤ 15 they never exceed WIN_SCORE.
- `remote_ready` dropping in WAIT_PEER keeps the FSM waiting. Dropping in any later state has no effect.
- The prescaler is `$clog2(CLK_HZ)` bits wide.

## Timing
- All outputs are registered.
- Values after reset, valid from the first cycle after `rst` is sampled high:
  - `state`=IDLE
  - `game_rst`=1
  - `local_ready`=0
  - `countdown`=0
  - `score1`=`score2`=0
  - `last_result`=00
  - prescaler 0
- Latencies:
  - Click edge at cycle n: `state`=WAIT_PEER and `local_ready`=1 at n+1.
  - Peer handshake complete: COUNTDOWN the next cycle.
  - COUNTDOWN lasts exactly COUNT_SEC×CLK_HZ cycles.
  - `game_rst` falls in the same cycle `state` shows PLAY.
  - `winner_valid` at cycle n: score update, `last_result`, `state`=RESULT and `game_rst`=1 all at n+1.
  - RESULT lasts exactly RESULT_HOLD_SEC×CLK_HZ cycles.
- Reset asserted mid-operation, in any state, restores all reset values on the next edge. This includes scores.

## Structure
- `game_pkg` holds:
  - `state_t` enum (3 bits).
  - Winner code constants `WIN_P1`=2'b01, `WIN_P2`=2'b10, `WIN_DRAW`=2'b11.
  - This package is shared with `game_logic` and the overlay renderer.
- One sub-module, `sec_tick`: a prescaler with a `clr` input and a one-cycle `tick` output every CLK_HZ cycles.
- The FSM, edge detector and score registers live in `game_flow_ctrl`.

## Test plan
All scenarios use CLK_HZ=10, COUNT_SEC=3, RESULT_HOLD_SEC=1, WIN_SCORE=2.
- Reset, then click with `remote_ready`=0:
  - WAIT_PEER with `local_ready`=1, held for 50 cycles.
  - Raise `remote_ready`: COUNTDOWN next cycle with `countdown`=3.
  - `countdown` shows 2 and 1 at +10 and +20 cycles; PLAY with `game_rst`=0 at +30.
- In PLAY, pulse `winner_code`=2'b10:
  - Next cycle `score2`=1, `last_result`=10, RESULT, `game_rst`=1.
  - IDLE after 10 cycles with `local_ready`=0.
- Pulse 2'b11, then in a later round 2'b00:
  - Draw: no score change, RESULT entered.
  - 00: ignored, FSM stays in PLAY.
- Two P1 wins, with `winner_code`=2'b01 twice:
  - MATCH_OVER after the second hold with `score1`=2.
  - Next click clears scores and returns to IDLE.
- `winner_valid` in IDLE/COUNTDOWN and a click held level through PLAY:
  - No state or score change.
  - Only a single rising edge is counted.
- Assert `rst` mid-COUNTDOWN with `score1`=1:
  - All outputs at reset values the next cycle.
